// File: rtl/morse_keyer.sv
// Morse keyer: takes one character code per valid/ready handshake, looks it
// up in the ITU table and keys a single on/off line in tick-based dot units.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a character; key off
// S_WAIT  | character latched, waiting for the first unit tick
// S_MARK  | key on for the current element (1 or DASH_UNITS units)
// S_SPACE | one-unit key-off gap between elements of a character
// S_CGAP  | trailing key-off gap (CGAP_UNITS, or WGAP_UNITS for a space)

module morse_keyer #(
    parameter int DASH_UNITS = 3,
    parameter int CGAP_UNITS = 3,
    parameter int WGAP_UNITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       char_valid,
    input  logic [5:0] char_code,
    output logic       char_ready,
    output logic       key,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_MARK,
        S_SPACE,
        S_CGAP
    } state_t;

    localparam logic [5:0] CODE_WSPACE = 6'd36;

    state_t     state, state_n;
    logic       key_n, done_n, err_n;
    logic [2:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [2:0] len_r, len_n;
    logic [4:0] mask_r, mask_n;
    logic       space_r, space_n;
    logic [2:0] tgt, tgt_n;

    logic [2:0] cnt_inc;
    logic [2:0] elem_len;
    logic [7:0] lk;

    // Table entry is {len[2:0], pattern[4:0]}; the pattern is left-aligned so
    // bit 4 is the first element (1 = dash). len 0 marks an invalid code.
    function automatic logic [7:0] lookup(input logic [5:0] c);
        logic [7:0] r;
        case (c)
            6'd0:  r = {3'd2, 5'b01000}; // A .-
            6'd1:  r = {3'd4, 5'b10000}; // B -...
            6'd2:  r = {3'd4, 5'b10100}; // C -.-.
            6'd3:  r = {3'd3, 5'b10000}; // D -..
            6'd4:  r = {3'd1, 5'b00000}; // E .
            6'd5:  r = {3'd4, 5'b00100}; // F ..-.
            6'd6:  r = {3'd3, 5'b11000}; // G --.
            6'd7:  r = {3'd4, 5'b00000}; // H ....
            6'd8:  r = {3'd2, 5'b00000}; // I ..
            6'd9:  r = {3'd4, 5'b01110}; // J .---
            6'd10: r = {3'd3, 5'b10100}; // K -.-
            6'd11: r = {3'd4, 5'b01000}; // L .-..
            6'd12: r = {3'd2, 5'b11000}; // M --
            6'd13: r = {3'd2, 5'b10000}; // N -.
            6'd14: r = {3'd3, 5'b11100}; // O ---
            6'd15: r = {3'd4, 5'b01100}; // P .--.
            6'd16: r = {3'd4, 5'b11010}; // Q --.-
            6'd17: r = {3'd3, 5'b01000}; // R .-.
            6'd18: r = {3'd3, 5'b00000}; // S ...
            6'd19: r = {3'd1, 5'b10000}; // T -
            6'd20: r = {3'd3, 5'b00100}; // U ..-
            6'd21: r = {3'd4, 5'b00010}; // V ...-
            6'd22: r = {3'd3, 5'b01100}; // W .--
            6'd23: r = {3'd4, 5'b10010}; // X -..-
            6'd24: r = {3'd4, 5'b10110}; // Y -.--
            6'd25: r = {3'd4, 5'b11000}; // Z --..
            6'd26: r = {3'd5, 5'b11111}; // 0 -----
            6'd27: r = {3'd5, 5'b01111}; // 1 .----
            6'd28: r = {3'd5, 5'b00111}; // 2 ..---
            6'd29: r = {3'd5, 5'b00011}; // 3 ...--
            6'd30: r = {3'd5, 5'b00001}; // 4 ....-
            6'd31: r = {3'd5, 5'b00000}; // 5 .....
            6'd32: r = {3'd5, 5'b10000}; // 6 -....
            6'd33: r = {3'd5, 5'b11000}; // 7 --...
            6'd34: r = {3'd5, 5'b11100}; // 8 ---..
            6'd35: r = {3'd5, 5'b11110}; // 9 ----.
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    assign char_ready = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign lk         = lookup(char_code);
    assign cnt_inc    = cnt + 3'd1;
    // The pattern register is shifted left per element, so bit 4 is always current.
    assign elem_len   = mask_r[4] ? 3'(DASH_UNITS) : 3'd1;

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            key     <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            cnt     <= 3'd0;
            idx     <= 3'd0;
            len_r   <= 3'd0;
            mask_r  <= 5'd0;
            space_r <= 1'b0;
            tgt     <= 3'd0;
        end else begin
            state   <= state_n;
            key     <= key_n;
            done    <= done_n;
            err     <= err_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            len_r   <= len_n;
            mask_r  <= mask_n;
            space_r <= space_n;
            tgt     <= tgt_n;
        end
    end

    // Next-state and next-output logic; every timed step advances only on tick.
    always_comb begin
        state_n = state;
        key_n   = key;
        done_n  = 1'b0;
        err_n   = 1'b0;
        cnt_n   = cnt;
        idx_n   = idx;
        len_n   = len_r;
        mask_n  = mask_r;
        space_n = space_r;
        tgt_n   = tgt;

        case (state)
            S_IDLE: begin
                key_n = 1'b0;
                if (char_valid) begin
                    cnt_n = 3'd0;
                    idx_n = 3'd0;
                    if (char_code == CODE_WSPACE) begin
                        space_n = 1'b1;
                        state_n = S_WAIT;
                    end else if (lk[7:5] != 3'd0) begin
                        space_n = 1'b0;
                        len_n   = lk[7:5];
                        mask_n  = lk[4:0];
                        state_n = S_WAIT;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (tick) begin
                    cnt_n = 3'd0;
                    idx_n = 3'd0;
                    if (space_r) begin
                        tgt_n   = 3'(WGAP_UNITS);
                        state_n = S_CGAP;
                    end else begin
                        key_n   = 1'b1;
                        state_n = S_MARK;
                    end
                end
            end
            S_MARK: begin
                if (tick) begin
                    if (cnt_inc == elem_len) begin
                        key_n = 1'b0;
                        cnt_n = 3'd0;
                        if ((idx + 3'd1) < len_r) begin
                            state_n = S_SPACE;
                        end else begin
                            tgt_n   = 3'(CGAP_UNITS);
                            state_n = S_CGAP;
                        end
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            S_SPACE: begin
                if (tick) begin
                    key_n   = 1'b1;
                    idx_n   = idx + 3'd1;
                    mask_n  = {mask_r[3:0], 1'b0};
                    state_n = S_MARK;
                end
            end
            S_CGAP: begin
                if (tick) begin
                    if (cnt_inc == tgt) begin
                        cnt_n   = 3'd0;
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            default: begin
                key_n   = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_morse_keyer.sv
// Scoreboard bench for morse_keyer: expected key runs, done and err events are
// queued when a character is offered and compared as the monitor sees them.

module tb_morse_keyer;

    localparam int TP    = 4;  // clock cycles per unit tick
    localparam int DASH  = 3;
    localparam int CGAP  = 3;
    localparam int WGAP  = 4;

    localparam int EV_KEYH = 1;
    localparam int EV_KEYL = 2;
    localparam int EV_DONE = 3;
    localparam int EV_ERR  = 4;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       char_valid = 1'b0;
    logic [5:0] char_code = 6'd0;
    logic       char_ready, key, busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;
    ev_t q[$];

    string tbl[36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----."
    };

    morse_keyer #(.DASH_UNITS(DASH), .CGAP_UNITS(CGAP), .WGAP_UNITS(WGAP)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .char_valid(char_valid), .char_code(char_code),
        .char_ready(char_ready), .key(key), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // free-running unit tick, one cycle in TP
    int ph = 0;
    always @(negedge clk) begin
        ph   = (ph == TP - 1) ? 0 : ph + 1;
        tick = (ph == 0);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void push_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endfunction

    // expected events for one offered code, from the dot/dash string table
    function automatic void push_char(input int code);
        string p;
        int units;
        if (code < 36) begin
            p = tbl[code];
            units = 0;
            for (int i = 0; i < p.len(); i++) begin
                int u;
                u = (p[i] == 8'h2d) ? DASH : 1;
                units += u;
                push_ev(EV_KEYH, u * TP);
                if (i < p.len() - 1) push_ev(EV_KEYL, TP);
            end
            push_ev(EV_DONE, 1 + units + (p.len() - 1) + CGAP);
        end else if (code == 36) begin
            push_ev(EV_DONE, 1 + WGAP);
        end else begin
            push_ev(EV_ERR, 0);
        end
    endfunction

    task automatic observe(input int kind, input int val);
        ev_t e;
        if (q.size() == 0) begin
            check("unexpected_event", kind * 1000 + val, -1);
        end else begin
            e = q.pop_front();
            check("event", kind * 1000 + val, e.kind * 1000 + e.val);
        end
    endtask

    // monitor state
    bit mon_en = 1'b0;
    bit key_q = 1'b0;
    bit infall = 1'b0;
    int hcnt = 0;
    int lcnt = 0;
    int tcnt = 0;
    int done_seen = 0;

    // ticks the DUT sees while busy
    always @(posedge clk) begin
        if (rst) tcnt = 0;
        else if (tick && busy) tcnt++;
    end

    // turn key runs, done and err into scoreboard events
    always @(negedge clk) begin
        if (done) done_seen++;
        if (mon_en) begin
            if (key) begin
                if (!key_q && infall) observe(EV_KEYL, lcnt);
                hcnt = key_q ? hcnt + 1 : 1;
            end else if (key_q) begin
                observe(EV_KEYH, hcnt);
                infall = 1'b1;
                lcnt = 1;
            end else begin
                lcnt++;
            end
            if (done) begin
                observe(EV_DONE, tcnt);
                tcnt = 0;
                infall = 1'b0;
            end
            if (err) observe(EV_ERR, 0);
            key_q = key;
        end
    end

    // call at a negedge; offers the code for exactly one accepting edge
    task automatic send(input int code);
        int guard;
        guard = 0;
        while (!char_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("send_ready", int'(char_ready), 1);
        push_char(code);
        char_valid = 1'b1;
        char_code  = 6'(code);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!done && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("done_timeout", int'(done), 1);
    endtask

    int extra[5] = '{10, 16, 35, 25, 1};
    int d0;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_key", int'(key), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_ready", int'(char_ready), 1);
        check("rst_busy", int'(busy), 0);

        send(4);   wait_idle();   // E
        send(0);   wait_idle();   // A
        send(26);  wait_idle();   // 0

        // word space then T accepted in the done cycle
        send(36);
        wait_done();
        check("b2b_ready", int'(char_ready), 1);
        send(19);
        wait_idle();

        // invalid code
        send(50);
        @(negedge clk);
        check("inv_err", int'(err), 1);
        check("inv_key", int'(key), 0);
        check("inv_ready", int'(char_ready), 1);
        @(negedge clk);
        check("inv_err_low", int'(err), 0);
        check("inv_ready2", int'(char_ready), 1);

        foreach (extra[i]) begin
            send(extra[i]);
            wait_idle();
        end

        // char_valid while busy is ignored
        send(4);
        repeat (3) @(negedge clk);
        char_valid = 1'b1;
        char_code  = 6'd19;
        repeat (2) @(negedge clk);
        char_valid = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);

        // reset mid-dash
        send(19);
        begin
            int guard;
            guard = 0;
            @(negedge clk);
            while (!key && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check("dash_start", int'(key), 1);
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_key", int'(key), 0);
        check("mid_rst_ready", int'(char_ready), 1);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        q.delete();
        d0 = done_seen;
        repeat (60) @(negedge clk);
        check("mid_rst_no_done", done_seen - d0, 0);
        @(posedge clk);
        #1;
        key_q  = 1'b0;
        infall = 1'b0;
        hcnt   = 0;
        lcnt   = 0;
        mon_en = 1'b1;
        @(negedge clk);
        send(4);
        wait_idle();

        repeat (20) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
